store_manage_unit: RTL

Slave-side consumer of the store-subsystem management channel (valid/ready with fence, fencevma, fencei, commit and itag). It turns each accepted request into either a one-cycle store-commit pulse to the store buffer, or an ordered fence sequence:

- drain the store buffer;
- optionally write back the D-cache, invalidate the I-cache and flush the TLBs;
- report completion back to the commit stage.

It sits between the commit stage (master) and the store buffer, caches and MMU.

---
 rtl/store_manage_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/store_manage_unit.sv
// store_manage_unit: consumer of the store-subsystem management channel.
// A plain commit becomes a one-cycle store-buffer commit pulse; a fence runs
// DRAIN -> [DCFL -> ICINV] -> [TLBFL] -> DONE and reports completion.
//
// Handshakes: the request channel transfers when req_valid_i && req_ready_o
// are both high at a rising edge. Each cache/TLB step raises its req on state
// entry and holds it until the matching ack is sampled high; the req then
// drops on the next edge. Acks seen while the req is low are ignored.
module store_manage_unit #(
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_fence_i,
  input  logic             req_fencevma_i,
  input  logic             req_fencei_i,
  input  logic             req_commit_i,
  input  logic [TAG_W-1:0] req_itag_i,
  output logic             sb_commit_valid_o,
  output logic [TAG_W-1:0] sb_commit_itag_o,
  input  logic             sb_empty_i,
  output logic             dc_flush_req_o,
  input  logic             dc_flush_ack_i,
  output logic             ic_inv_req_o,
  input  logic             ic_inv_ack_i,
  output logic             tlb_flush_req_o,
  input  logic             tlb_flush_ack_i,
  output logic             done_valid_o,
  output logic [TAG_W-1:0] done_itag_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    DCFL  = 3'd2,
    ICINV = 3'd3,
    TLBFL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] itag_q;
  logic             fencevma_q;
  logic             fencei_q;
  logic             accept;
  logic             any_fence;

  // A plain fence needs no latched flag of its own: it only drains and
  // completes, which is the default path out of DRAIN.
  assign accept      = req_valid_i && req_ready_o;
  assign any_fence   = req_fence_i || req_fencevma_i || req_fencei_i;
  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

  // Fence sequencer with registered handshake, commit and completion outputs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state             <= IDLE;
      itag_q            <= '0;
      fencevma_q        <= 1'b0;
      fencei_q          <= 1'b0;
      sb_commit_valid_o <= 1'b0;
      sb_commit_itag_o  <= '0;
      dc_flush_req_o    <= 1'b0;
      ic_inv_req_o      <= 1'b0;
      tlb_flush_req_o   <= 1'b0;
      done_valid_o      <= 1'b0;
      done_itag_o       <= '0;
    end else begin
      sb_commit_valid_o <= 1'b0;
      done_valid_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (any_fence) begin
              itag_q     <= req_itag_i;
              fencevma_q <= req_fencevma_i;
              fencei_q   <= req_fencei_i;
              state      <= DRAIN;
            end else if (req_commit_i) begin
              sb_commit_valid_o <= 1'b1;
              sb_commit_itag_o  <= req_itag_i;
            end
          end
        end
        DRAIN: begin
          if (sb_empty_i) begin
            if (fencei_q) begin
              dc_flush_req_o <= 1'b1;
              state          <= DCFL;
            end else if (fencevma_q) begin
              tlb_flush_req_o <= 1'b1;
              state           <= TLBFL;
            end else begin
              done_valid_o <= 1'b1;
              done_itag_o  <= itag_q;
              state        <= DONE;
            end
          end
        end
        DCFL: begin
          if (dc_flush_req_o && dc_flush_ack_i) begin
            dc_flush_req_o <= 1'b0;
            ic_inv_req_o   <= 1'b1;
            state          <= ICINV;
          end
        end
        ICINV: begin
          if (ic_inv_req_o && ic_inv_ack_i) begin
            ic_inv_req_o <= 1'b0;
            if (fencevma_q) begin
              tlb_flush_req_o <= 1'b1;
              state           <= TLBFL;
            end else begin
              done_valid_o <= 1'b1;
              done_itag_o  <= itag_q;
              state        <= DONE;
            end
          end
        end
        TLBFL: begin
          if (tlb_flush_req_o && tlb_flush_ack_i) begin
            tlb_flush_req_o <= 1'b0;
            done_valid_o    <= 1'b1;
            done_itag_o     <= itag_q;
            state           <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
